serial_add_seq: RTL

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq_pkg.sv | 14 +
 rtl/add3_slice.sv | 20 ++
 rtl/serial_add_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/serial_add_seq_pkg.sv
// Shared constants for the chunk-serial adder: state encoding and chunk width.
package serial_add_seq_pkg;
    localparam int CW = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;
endpackage

// File: rtl/add3_slice.sv
// Combinational 3-bit ripple adder exposing the carry out of every bit position.
module add3_slice
    import serial_add_seq_pkg::*;
(
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic [CW-1:0] carry
);
    logic [CW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        assign carry[i] = c[i+1];
    end
endmodule

// File: rtl/serial_add_seq.sv
// Chunk-serial adder: one 3-bit slice is reused CHUNKS times, LSB chunk first,
// with a valid/ready handshake on both the operand and the result side.
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int N      = 3 * CHUNKS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    state_t        state, state_nxt;
    logic [KW-1:0] k;
    logic          carry;
    logic [N-1:0]  a_q, b_q;
    logic [CW-1:0] slice_sum, slice_carry;
    logic          last;
    logic          unused_carry0;

    add3_slice u_slice (
        .a     (a_q[k*CW +: CW]),
        .b     (b_q[k*CW +: CW]),
        .cin   (carry),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    // Only the top two slice carries matter: chaining and the final flags.
    assign unused_carry0 = slice_carry[0];

    assign last      = (k == KW'(CHUNKS - 1));
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        k     <= '0;
                    end
                end
                ST_RUN: begin
                    sum[k*CW +: CW] <= slice_sum;
                    carry           <= slice_carry[CW-1];
                    k               <= k + 1'b1;
                    if (last) begin
                        cout <= slice_carry[CW-1];
                        ovf  <= slice_carry[CW-1] ^ slice_carry[CW-2];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
